// File: rtl/lifo_arb_pkg.sv
// Shared types and helpers for the LIFO arbiter: FSM state encoding and id-width sizing.
package lifo_arb_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } arb_state_e;

    // Client id width; a two-client build still needs one id bit.
    function automatic int calc_idw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant over an eligible vector, priority rotating past the last winner.
module rr_arbiter
    import lifo_arb_pkg::*;
#(
    parameter int  NUM_REQ = 4,
    localparam int IDW     = calc_idw(NUM_REQ)
) (
    input  logic               clk_i,
    input  logic               srst_i,
    input  logic [NUM_REQ-1:0] eligible_i,
    input  logic               advance_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDW-1:0]     grant_idx_o
);

    logic [IDW-1:0] ptr_q;
    logic           found;

    // Scan from the pointer, wrapping; first eligible client wins.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            int cand;
            cand = (int'(ptr_q) + i) % NUM_REQ;
            if (!found && eligible_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                grant_idx_o   = IDW'(cand);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            ptr_q <= '0;
        end else if (advance_i) begin
            ptr_q <= (grant_idx_o == IDW'(NUM_REQ - 1)) ? '0 : grant_idx_o + 1'b1;
        end
    end

endmodule

// File: rtl/lifo_arbiter.sv
// Shares one LIFO among NUM_REQ valid/ready clients; returns tagged pop data and offers a drain-to-empty flush.
module lifo_arbiter
    import lifo_arb_pkg::*;
#(
    parameter int  NUM_REQ = 4,
    parameter int  DWIDTH  = 16,
    parameter int  AWIDTH  = 8,
    localparam int IDW     = calc_idw(NUM_REQ)
) (
    input  logic                      clk_i,
    input  logic                      srst_i,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ-1:0]        req_pop_i,
    input  logic [NUM_REQ*DWIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    output logic                      rsp_valid_o,
    output logic [IDW-1:0]            rsp_id_o,
    output logic [DWIDTH-1:0]         rsp_data_o,
    input  logic                      flush_i,
    output logic                      flush_busy_o,
    output logic                      flush_done_o,
    output logic                      lifo_wrreq_o,
    output logic [DWIDTH-1:0]         lifo_data_o,
    output logic                      lifo_rdreq_o,
    input  logic [DWIDTH-1:0]         lifo_q_i,
    input  logic                      lifo_empty_i,
    input  logic                      lifo_full_i
);

    if (AWIDTH < 1 || NUM_REQ < 2 || NUM_REQ > 16) begin : g_param_check
        $error("lifo_arbiter: unsupported parameter set");
    end

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant;
    logic [IDW-1:0]     grant_idx;
    logic               gnt_any, gnt_pop;
    logic               run_ok, flush_active;
    logic               rsp_vld_p1;
    logic [IDW-1:0]     rsp_id_p1;

    assign run_ok       = (state_q == RUN) && !srst_i;
    assign flush_active = (state_q == FLUSH) && !srst_i;

    // Eligibility checks the flags as they stand, which lag each access by one cycle.
    always_comb begin
        eligible = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            eligible[k] = run_ok && req_valid_i[k] &&
                          (req_pop_i[k] ? !lifo_empty_i : !lifo_full_i);
        end
    end

    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_rr (
        .clk_i      (clk_i),
        .srst_i     (srst_i),
        .eligible_i (eligible),
        .advance_i  (gnt_any),
        .grant_o    (grant),
        .grant_idx_o(grant_idx)
    );

    assign gnt_any      = |grant;
    assign gnt_pop      = gnt_any && req_pop_i[grant_idx];
    assign req_ready_o  = grant;
    assign lifo_wrreq_o = gnt_any && !gnt_pop;
    assign lifo_data_o  = gnt_any ? req_data_i[int'(grant_idx)*DWIDTH +: DWIDTH] : '0;
    assign lifo_rdreq_o = gnt_pop || (flush_active && !lifo_empty_i);
    assign flush_busy_o = flush_active;
    assign flush_done_o = flush_active && lifo_empty_i;

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (flush_i) state_d = FLUSH;
            FLUSH:   if (lifo_empty_i) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // p0 -> p1: pop grant becomes a response next cycle, when the LIFO presents q.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            rsp_vld_p1 <= 1'b0;
            rsp_id_p1  <= '0;
        end else begin
            rsp_vld_p1 <= gnt_pop;
            if (gnt_pop) rsp_id_p1 <= grant_idx;
        end
    end

    assign rsp_valid_o = rsp_vld_p1;
    assign rsp_id_o    = rsp_id_p1;
    assign rsp_data_o  = rsp_vld_p1 ? lifo_q_i : '0;

endmodule

// File: tb/tb_lifo_arbiter.sv
// Bench for lifo_arbiter: behavioural 256-deep LIFO, directed stimulus, queue-based response scoreboard.
module tb_lifo_arbiter;

    localparam int NR = 4;
    localparam int DW = 16;
    localparam int DEPTH = 256;

    logic            clk_i_tb = 1'b0;
    logic            srst_i;
    logic [NR-1:0]   req_valid_i, req_pop_i, req_ready_o;
    logic [NR*DW-1:0] req_data_i;
    logic            rsp_valid_o;
    logic [1:0]      rsp_id_o;
    logic [DW-1:0]   rsp_data_o;
    logic            flush_i, flush_busy_o, flush_done_o;
    logic            lifo_wrreq_o, lifo_rdreq_o;
    logic [DW-1:0]   lifo_data_o;
    logic [DW-1:0]   lifo_q = '0;
    logic            lifo_empty, lifo_full;

    always #5 clk_i_tb = ~clk_i_tb;

    lifo_arbiter #(.NUM_REQ(NR), .DWIDTH(DW), .AWIDTH(8)) dut (
        .clk_i(clk_i_tb), .srst_i(srst_i),
        .req_valid_i(req_valid_i), .req_pop_i(req_pop_i), .req_data_i(req_data_i),
        .req_ready_o(req_ready_o),
        .rsp_valid_o(rsp_valid_o), .rsp_id_o(rsp_id_o), .rsp_data_o(rsp_data_o),
        .flush_i(flush_i), .flush_busy_o(flush_busy_o), .flush_done_o(flush_done_o),
        .lifo_wrreq_o(lifo_wrreq_o), .lifo_data_o(lifo_data_o), .lifo_rdreq_o(lifo_rdreq_o),
        .lifo_q_i(lifo_q), .lifo_empty_i(lifo_empty), .lifo_full_i(lifo_full)
    );

    // Behavioural LIFO: flags and q update on the clock after each access.
    logic [DW-1:0] mem [DEPTH];
    int cnt = 0;
    assign lifo_empty = (cnt == 0);
    assign lifo_full  = (cnt == DEPTH);
    always @(posedge clk_i_tb) begin
        if (lifo_wrreq_o && cnt < DEPTH) begin
            mem[cnt] <= lifo_data_o;
            cnt      <= cnt + 1;
        end else if (lifo_rdreq_o && cnt > 0) begin
            lifo_q <= mem[cnt-1];
            cnt    <= cnt - 1;
        end
    end

    int cyc = 0;
    always @(posedge clk_i_tb) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  id;
        logic [15:0] data;
        int          at;
    } exp_t;
    exp_t expq[$];

    task automatic expect_rsp(input logic [1:0] id, input logic [15:0] data);
        exp_t e;
        e.id = id; e.data = data; e.at = cyc + 1;
        expq.push_back(e);
    endtask

    // Monitor: every presented response must match the head of the scoreboard.
    always begin
        exp_t e;
        @(negedge clk_i_tb);
        #2;
        if (lifo_wrreq_o && lifo_rdreq_o) chk("wr_rd_overlap", 32'd1, 32'd0);
        if (rsp_valid_o === 1'b1) begin
            if (expq.size() == 0) begin
                chk("rsp_unexpected", {16'd0, rsp_data_o}, 32'hFFFF_FFFF);
            end else begin
                e = expq.pop_front();
                chk("rsp_id", 32'(rsp_id_o), 32'(e.id));
                chk("rsp_data", 32'(rsp_data_o), 32'(e.data));
                chk("rsp_latency", 32'(cyc), 32'(e.at));
            end
        end
    end

    task automatic set_data(input int k, input logic [15:0] d);
        req_data_i[k*DW +: DW] = d;
    endtask

    task automatic do_reset();
        @(negedge clk_i_tb);
        srst_i = 1'b1; req_valid_i = '0; req_pop_i = '0; flush_i = 1'b0;
        @(negedge clk_i_tb);
        srst_i = 1'b0;
    endtask

    task automatic push_words(input int k, input int n, input logic [15:0] base);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_i_tb);
            req_valid_i = 4'(1 << k); req_pop_i = '0; set_data(k, base + 16'(i));
            #1 chk("push_ready", 32'(req_ready_o), 32'(1 << k));
        end
        @(negedge clk_i_tb);
        req_valid_i = '0;
    endtask

    // Pulse flush with client 1 requesting a push throughout; expects n drain reads then done.
    task automatic flush_run(input int n);
        @(negedge clk_i_tb);
        flush_i = 1'b1;
        #1 chk("flush_start_busy", 32'(flush_busy_o), 32'd0);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_i_tb);
            flush_i = 1'b0; req_valid_i = 4'b0010; req_pop_i = '0; set_data(1, 16'hDEAD);
            #1;
            chk("flush_busy", 32'(flush_busy_o), 32'd1);
            chk("flush_rdreq", 32'(lifo_rdreq_o), 32'd1);
            chk("flush_ready", 32'(req_ready_o), 32'd0);
            chk("flush_early_done", 32'(flush_done_o), 32'd0);
        end
        @(negedge clk_i_tb);
        flush_i = 1'b0; req_valid_i = '0;
        #1;
        chk("flush_done", 32'(flush_done_o), 32'd1);
        chk("flush_last_rdreq", 32'(lifo_rdreq_o), 32'd0);
        @(negedge clk_i_tb);
        #1;
        chk("flush_done_pulse", 32'(flush_done_o), 32'd0);
        chk("flush_back_run", 32'(flush_busy_o), 32'd0);
        chk("flush_empty", 32'(lifo_empty), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] w1 [3];
        w1[0] = 16'h1111; w1[1] = 16'h2222; w1[2] = 16'h3333;
        srst_i = 1'b1; req_valid_i = '0; req_pop_i = '0; req_data_i = '0; flush_i = 1'b0;

        // Reset state
        repeat (2) @(negedge clk_i_tb);
        srst_i = 1'b0;
        #1;
        chk("rst_ready", 32'(req_ready_o), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id_o), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data_o), 32'd0);
        chk("rst_busy", 32'(flush_busy_o), 32'd0);
        chk("rst_done", 32'(flush_done_o), 32'd0);
        chk("rst_wrreq", 32'(lifo_wrreq_o), 32'd0);
        chk("rst_rdreq", 32'(lifo_rdreq_o), 32'd0);
        chk("rst_data", 32'(lifo_data_o), 32'd0);

        // Single client push x3, pop x3
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i_tb);
            req_valid_i = 4'b0001; req_pop_i = '0; set_data(0, w1[i]);
            #1;
            chk("t1_push_ready", 32'(req_ready_o), 32'd1);
            chk("t1_wrreq", 32'(lifo_wrreq_o), 32'd1);
            chk("t1_wdata", 32'(lifo_data_o), 32'(w1[i]));
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i_tb);
            req_valid_i = 4'b0001; req_pop_i = 4'b0001;
            #1;
            chk("t1_pop_ready", 32'(req_ready_o), 32'd1);
            chk("t1_rdreq", 32'(lifo_rdreq_o), 32'd1);
            expect_rsp(2'd0, w1[2-i]);
        end
        @(negedge clk_i_tb);
        req_valid_i = '0; req_pop_i = '0;

        // All four clients push until full
        do_reset();
        for (int k = 0; k < NR; k++) set_data(k, 16'hB000 + 16'(k));
        for (int n = 0; n < DEPTH; n++) begin
            @(negedge clk_i_tb);
            req_valid_i = 4'hF; req_pop_i = '0;
            #1;
            chk("t2_rr_grant", 32'(req_ready_o), 32'(1 << (n % NR)));
            chk("t2_wdata", 32'(lifo_data_o), 32'(16'hB000 + 16'(n % NR)));
        end
        @(negedge clk_i_tb);
        #1;
        chk("t2_full_flag", 32'(lifo_full), 32'd1);
        chk("t2_full_ready", 32'(req_ready_o), 32'd0);
        chk("t2_full_wrreq", 32'(lifo_wrreq_o), 32'd0);
        @(negedge clk_i_tb);
        req_valid_i = '0;

        // Drain the full stack
        flush_run(DEPTH);

        // Mixed pop/push with five words stacked
        push_words(0, 5, 16'h5000);
        do_reset();
        @(negedge clk_i_tb);
        req_valid_i = 4'hF; req_pop_i = 4'b0101;
        set_data(1, 16'h6001); set_data(3, 16'h6003);
        #1;
        chk("t3_grant0", 32'(req_ready_o), 32'b0001);
        chk("t3_rd0", 32'(lifo_rdreq_o), 32'd1);
        expect_rsp(2'd0, 16'h5004);
        @(negedge clk_i_tb);
        #1;
        chk("t3_grant1", 32'(req_ready_o), 32'b0010);
        chk("t3_wr1", 32'(lifo_wrreq_o & ~lifo_rdreq_o), 32'd1);
        @(negedge clk_i_tb);
        #1;
        chk("t3_grant2", 32'(req_ready_o), 32'b0100);
        chk("t3_rd2", 32'(lifo_rdreq_o & ~lifo_wrreq_o), 32'd1);
        expect_rsp(2'd2, 16'h6001);
        @(negedge clk_i_tb);
        #1;
        chk("t3_grant3", 32'(req_ready_o), 32'b1000);
        @(negedge clk_i_tb);
        req_valid_i = '0; req_pop_i = '0;
        #1 chk("t3_usedw", 32'(cnt), 32'd5);

        // Pop on empty stalls; a concurrent push from another client is served
        flush_run(5);
        @(negedge clk_i_tb);
        req_valid_i = 4'b0001; req_pop_i = 4'b0001;
        #1;
        chk("t4_empty_ready", 32'(req_ready_o), 32'd0);
        chk("t4_empty_rdreq", 32'(lifo_rdreq_o), 32'd0);
        @(negedge clk_i_tb);
        req_valid_i = 4'b0011; set_data(1, 16'h7777);
        #1;
        chk("t4_push_wins", 32'(req_ready_o), 32'b0010);
        chk("t4_push_wr", 32'(lifo_wrreq_o), 32'd1);
        chk("t4_no_rd", 32'(lifo_rdreq_o), 32'd0);
        @(negedge clk_i_tb);
        #1;
        chk("t4_pop_now", 32'(req_ready_o), 32'b0001);
        expect_rsp(2'd0, 16'h7777);
        @(negedge clk_i_tb);
        req_valid_i = '0; req_pop_i = '0;

        // Ten-word flush, then flush of an empty stack
        push_words(2, 10, 16'h00A0);
        flush_run(10);
        flush_run(0);

        // Reset during the fourth cycle of a ten-word flush
        push_words(3, 10, 16'h00C0);
        @(negedge clk_i_tb);
        flush_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i_tb);
            flush_i = 1'b0;
            #1 chk("t6_rdreq", 32'(lifo_rdreq_o), 32'd1);
        end
        @(negedge clk_i_tb);
        srst_i = 1'b1;
        @(negedge clk_i_tb);
        srst_i = 1'b0;
        #1;
        chk("t6_busy", 32'(flush_busy_o), 32'd0);
        chk("t6_done", 32'(flush_done_o), 32'd0);
        chk("t6_rdreq_off", 32'(lifo_rdreq_o), 32'd0);
        chk("t6_wrreq_off", 32'(lifo_wrreq_o), 32'd0);
        chk("t6_ready_off", 32'(req_ready_o), 32'd0);
        chk("t6_rsp_off", 32'(rsp_valid_o), 32'd0);
        @(negedge clk_i_tb);
        req_valid_i = 4'b0011; req_pop_i = '0;
        set_data(0, 16'hC000); set_data(1, 16'hC001);
        #1;
        chk("t6_ptr_zero", 32'(req_ready_o), 32'b0001);
        chk("t6_no_done", 32'(flush_done_o), 32'd0);
        @(negedge clk_i_tb);
        req_valid_i = '0;

        repeat (3) @(negedge clk_i_tb);
        chk("scoreboard_drained", 32'(expq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
